uart_arbiter: RTL and testbench

Round-robin arbiter sharing the single word-wide UART port (read/write word, response pulse) between `NUM_REQ` requesters, e.g. the debug controller and the processor memory-mapped bridge. It holds each requester's request until completion, issues one UART transaction at a time, routes the response pulse and read data back to the owner, and absorbs the UART's two-cycle write-response pulse. It sits between the requesters and the `UART` instance in the controller top level.

---
 rtl/uart_arbiter_pkg.sv | 18 +
 rtl/uart_rr_picker.sv | 30 +++
 rtl/uart_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_uart_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arbiter_pkg.sv
// Shared types and constants for the UART port arbiter.
package uart_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } arb_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } arb_op_t;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker: first pending requester at or after the
// pointer, wrapping around. Emits a one-hot grant plus a valid flag.
module uart_rr_picker #(
    parameter int NUM_REQ   = 2,
    parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   pending_i,
    input  logic [REQ_IDX_W-1:0] ptr_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 valid_o
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] hot2;

    // Rotate the doubled pending vector so the pointer lands on bit 0, pick the
    // lowest set bit, then fold the doubled one-hot back onto NUM_REQ bits.
    always_comb begin
        dbl  = {pending_i, pending_i} >> ptr_i;
        hot2 = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                hot2 = {{(2*NUM_REQ-1){1'b0}}, 1'b1} << (int'(ptr_i) + k);
            end
        end
        grant_o = hot2[NUM_REQ-1:0] | hot2[2*NUM_REQ-1:NUM_REQ];
        valid_o = |pending_i;
    end

endmodule

// File: rtl/uart_arbiter.sv
// Round-robin arbiter sharing one word-wide UART port between NUM_REQ
// requesters. One transaction in flight at a time; a DRAIN cycle after each
// completion swallows the UART's second write-response pulse.
module uart_arbiter
    import uart_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_read_i,
    input  logic [NUM_REQ-1:0]        req_write_i,
    input  logic [NUM_REQ*WORD_W-1:0] req_write_data_i,
    output logic [NUM_REQ-1:0]        req_read_response_o,
    output logic [NUM_REQ-1:0]        req_write_response_o,
    output logic [WORD_W-1:0]         req_read_data_o,
    output logic                      uart_read_o,
    output logic                      uart_write_o,
    output logic [WORD_W-1:0]         uart_write_data_o,
    input  logic                      uart_read_response_i,
    input  logic                      uart_write_response_i,
    input  logic [WORD_W-1:0]         uart_read_data_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o,
    output logic                      proto_err_o
);

    arb_state_t           state_q, state_d;
    arb_op_t              op_q, op_d;
    logic [REQ_IDX_W-1:0] ptr_q, ptr_d;
    logic [REQ_IDX_W-1:0] owner_q, owner_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   rd_resp_q, rd_resp_d;
    logic [NUM_REQ-1:0]   wr_resp_q, wr_resp_d;
    logic                 uart_rd_q, uart_rd_d;
    logic                 uart_wr_q, uart_wr_d;
    logic [WORD_W-1:0]    wdata_q, wdata_d;
    logic [WORD_W-1:0]    rdata_q, rdata_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic [NUM_REQ-1:0]   pending;
    logic [NUM_REQ-1:0]   pick_grant;
    logic                 pick_valid;
    logic [REQ_IDX_W-1:0] pick_idx;
    logic [WORD_W-1:0]    pick_wdata;
    logic                 pick_wr;
    logic                 done;

    assign pending = req_read_i | req_write_i;

    uart_rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .REQ_IDX_W (REQ_IDX_W)
    ) u_picker (
        .pending_i (pending),
        .ptr_i     (ptr_q),
        .grant_o   (pick_grant),
        .valid_o   (pick_valid)
    );

    // Translate the one-hot pick into an index, its write word and its op.
    always_comb begin
        pick_idx   = '0;
        pick_wdata = '0;
        pick_wr    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                pick_idx   = REQ_IDX_W'(i);
                pick_wdata = req_write_data_i[i*WORD_W +: WORD_W];
                pick_wr    = req_write_i[i];
            end
        end
    end

    // Next-state and registered-output logic of the arbitration FSM.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        rd_resp_d = '0;
        wr_resp_d = '0;
        uart_rd_d = 1'b0;
        uart_wr_d = 1'b0;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (uart_read_response_i || uart_write_response_i) begin
                    err_d = 1'b1;
                end
                if (pick_valid) begin
                    owner_d = pick_idx;
                    grant_d = pick_grant;
                    // Write wins when both bits are set; the read stays pending.
                    if (pick_wr) begin
                        op_d      = OP_WRITE;
                        uart_wr_d = 1'b1;
                        wdata_d   = pick_wdata;
                    end else begin
                        op_d      = OP_READ;
                        uart_rd_d = 1'b1;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (uart_read_response_i || uart_write_response_i) begin
                    err_d = 1'b1;
                end
                state_d = WAIT;
            end
            WAIT: begin
                if (op_q == OP_READ) begin
                    if (uart_write_response_i) begin
                        err_d = 1'b1;
                    end
                    if (uart_read_response_i) begin
                        rd_resp_d = grant_q;
                        rdata_d   = uart_read_data_i;
                        done      = 1'b1;
                    end
                end else begin
                    if (uart_read_response_i) begin
                        err_d = 1'b1;
                    end
                    if (uart_write_response_i) begin
                        wr_resp_d = grant_q;
                        done      = 1'b1;
                    end
                end
                if (done) begin
                    grant_d = '0;
                    ptr_d   = (owner_q == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Responses here are the tail of a two-cycle write pulse.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; async reset returns everything to idle zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= OP_READ;
            ptr_q     <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            rd_resp_q <= '0;
            wr_resp_q <= '0;
            uart_rd_q <= 1'b0;
            uart_wr_q <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            rd_resp_q <= rd_resp_d;
            wr_resp_q <= wr_resp_d;
            uart_rd_q <= uart_rd_d;
            uart_wr_q <= uart_wr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign req_read_response_o  = rd_resp_q;
    assign req_write_response_o = wr_resp_q;
    assign req_read_data_o      = rdata_q;
    assign uart_read_o          = uart_rd_q;
    assign uart_write_o         = uart_wr_q;
    assign uart_write_data_o    = wdata_q;
    assign grant_o              = grant_q;
    assign busy_o               = busy_q;
    assign proto_err_o          = err_q;

endmodule

// File: tb/tb_uart_arbiter.sv
// Self-checking bench for uart_arbiter: transaction table, hand-written corner
// sequences, then randomized traffic against a round-robin reference model.
module tb_uart_arbiter;

    localparam int N = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_read_i;
    logic [N-1:0]    req_write_i;
    logic [N*32-1:0] req_write_data_i;
    logic [N-1:0]    req_read_response_o;
    logic [N-1:0]    req_write_response_o;
    logic [31:0]     req_read_data_o;
    logic            uart_read_o;
    logic            uart_write_o;
    logic [31:0]     uart_write_data_o;
    logic            uart_read_response_i;
    logic            uart_write_response_i;
    logic [31:0]     uart_read_data_i;
    logic [N-1:0]    grant_o;
    logic            busy_o;
    logic            proto_err_o;

    always #5 clk = ~clk;

    uart_arbiter #(.NUM_REQ(N)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req_read_i            (req_read_i),
        .req_write_i           (req_write_i),
        .req_write_data_i      (req_write_data_i),
        .req_read_response_o   (req_read_response_o),
        .req_write_response_o  (req_write_response_o),
        .req_read_data_o       (req_read_data_o),
        .uart_read_o           (uart_read_o),
        .uart_write_o          (uart_write_o),
        .uart_write_data_o     (uart_write_data_o),
        .uart_read_response_i  (uart_read_response_i),
        .uart_write_response_i (uart_write_response_i),
        .uart_read_data_i      (uart_read_data_i),
        .grant_o               (grant_o),
        .busy_o                (busy_o),
        .proto_err_o           (proto_err_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_issue(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (uart_read_o || uart_write_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("issue_timeout", 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_read_i = '0;
        req_write_i = '0;
        uart_read_response_i = 1'b0;
        uart_write_response_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic [31:0] urd;
        logic [1:0]  eg;
        logic        ew;
    } vec_t;

    vec_t vecs[8];

    // Random-phase reference model state
    bit   [1:0]  m_rd, m_wr, p_rd, p_wr, just, op;
    logic [31:0] m_wd[2];
    logic [31:0] p_wd[2];
    logic [31:0] m_rdata;
    logic [31:0] last_rd;
    int          m_ptr, m_owner, cnt, e, idx, n_txn;
    bit          m_opw, m_act, second, ok;
    vec_t        v;

    initial begin
        // rd, wr, wd0, wd1, uart read word, expected grant, expected write
        vecs[0] = '{2'b01, 2'b00, 32'h0, 32'h0, 32'hDEADBEEF, 2'b01, 1'b0};
        vecs[1] = '{2'b00, 2'b10, 32'h0, 32'h12345678, 32'h0, 2'b10, 1'b1};
        vecs[2] = '{2'b11, 2'b00, 32'h0, 32'h0, 32'h11110000, 2'b01, 1'b0};
        vecs[3] = '{2'b11, 2'b00, 32'h0, 32'h0, 32'h22220001, 2'b10, 1'b0};
        vecs[4] = '{2'b01, 2'b01, 32'hA5A5A5A5, 32'h0, 32'h0, 2'b01, 1'b1};
        vecs[5] = '{2'b01, 2'b10, 32'h0, 32'h0BADF00D, 32'h0, 2'b10, 1'b1};
        vecs[6] = '{2'b10, 2'b00, 32'h0, 32'h0, 32'h76543210, 2'b10, 1'b0};
        vecs[7] = '{2'b00, 2'b11, 32'hC0FFEE00, 32'hFFFF0001, 32'h0, 2'b01, 1'b1};

        rst_n = 1'b0;
        req_read_i = '0;
        req_write_i = '0;
        req_write_data_i = '0;
        uart_read_response_i = 1'b0;
        uart_write_response_i = 1'b0;
        uart_read_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {grant_o, busy_o, uart_read_o, uart_write_o, proto_err_o,
                              req_read_response_o, req_write_response_o}, 0);
        chk("reset_data", {req_read_data_o, uart_write_data_o}, 0);
        rst_n = 1'b1;
        last_rd = 32'h0;

        // Table: one full transaction per entry, pointer carried between entries
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            req_read_i = v.rd;
            req_write_i = v.wr;
            req_write_data_i = {v.wd1, v.wd0};
            tick();
            chk("v_grant", grant_o, v.eg);
            chk("v_op", {uart_write_o, uart_read_o}, v.ew ? 2'b10 : 2'b01);
            chk("v_busy", busy_o, 1);
            if (v.ew) chk("v_wdata", uart_write_data_o, v.eg[1] ? v.wd1 : v.wd0);
            tick();
            chk("v_pulse_clr", {uart_write_o, uart_read_o}, 0);
            if (v.ew) begin
                uart_write_response_i = 1'b1;
            end else begin
                uart_read_response_i = 1'b1;
                uart_read_data_i = v.urd;
            end
            tick();
            uart_read_response_i = 1'b0;
            uart_read_data_i = 32'h0BAD0BAD;
            chk("v_wresp", req_write_response_o, v.ew ? v.eg : 2'b00);
            chk("v_rresp", req_read_response_o, v.ew ? 2'b00 : v.eg);
            if (v.ew) begin
                chk("v_wdata_hold", uart_write_data_o, v.eg[1] ? v.wd1 : v.wd0);
            end else begin
                chk("v_rdata", req_read_data_o, v.urd);
                last_rd = v.urd;
            end
            req_read_i = '0;
            req_write_i = '0;
            tick();
            uart_write_response_i = 1'b0;
            chk("v_idle", {busy_o, grant_o, req_read_response_o, req_write_response_o}, 0);
            chk("v_rdata_hold", req_read_data_o, last_rd);
            chk("v_err", proto_err_o, 0);
        end

        // Async reset while a read waits for its response
        req_read_i = 2'b10;
        tick();
        tick();
        chk("mid_busy", busy_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctl", {grant_o, busy_o, uart_read_o, uart_write_o, proto_err_o,
                              req_read_response_o, req_write_response_o}, 0);
        chk("rst_async_data", {req_read_data_o, uart_write_data_o}, 0);
        req_read_i = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fairness: both requesters hold write requests continuously
        req_write_i = 2'b11;
        req_write_data_i = {32'hB1B1B1B1, 32'hA0A0A0A0};
        for (int t = 0; t < 8; t++) begin
            wait_issue(ok);
            if (!ok) break;
            chk("fair_grant", grant_o, (t % 2 == 0) ? 2'b01 : 2'b10);
            chk("fair_wdata", uart_write_data_o, (t % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
            tick();
            uart_write_response_i = 1'b1;
            tick();
            chk("fair_wresp", req_write_response_o, (t % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            uart_write_response_i = 1'b0;
        end
        req_write_i = '0;
        tick();
        tick();

        // Read and write on the same requester: write first, read later
        req_read_i = 2'b01;
        req_write_i = 2'b01;
        req_write_data_i = {32'h0, 32'hCAFEF00D};
        wait_issue(ok);
        chk("rw_first_op", {uart_write_o, uart_read_o}, 2'b10);
        chk("rw_first_grant", grant_o, 2'b01);
        chk("rw_wdata", uart_write_data_o, 32'hCAFEF00D);
        tick();
        uart_write_response_i = 1'b1;
        tick();
        chk("rw_wresp", req_write_response_o, 2'b01);
        req_write_i = '0;
        tick();
        uart_write_response_i = 1'b0;
        wait_issue(ok);
        chk("rw_second_op", {uart_write_o, uart_read_o}, 2'b01);
        chk("rw_second_grant", grant_o, 2'b01);
        tick();
        uart_read_response_i = 1'b1;
        uart_read_data_i = 32'h5A5A1234;
        tick();
        uart_read_response_i = 1'b0;
        chk("rw_rresp", req_read_response_o, 2'b01);
        chk("rw_rdata", req_read_data_o, 32'h5A5A1234);
        req_read_i = '0;
        tick();

        // Protocol error: write response while a read is in flight
        req_read_i = 2'b10;
        wait_issue(ok);
        chk("pe_grant", grant_o, 2'b10);
        tick();
        uart_write_response_i = 1'b1;
        tick();
        uart_write_response_i = 1'b0;
        chk("pe_err_set", proto_err_o, 1);
        chk("pe_no_resp", {req_read_response_o, req_write_response_o}, 0);
        chk("pe_still_busy", busy_o, 1);
        tick();
        uart_read_response_i = 1'b1;
        uart_read_data_i = 32'h0F0F0F0F;
        tick();
        uart_read_response_i = 1'b0;
        chk("pe_rresp", req_read_response_o, 2'b10);
        chk("pe_rdata", req_read_data_o, 32'h0F0F0F0F);
        req_read_i = '0;
        tick();
        tick();
        chk("pe_sticky", proto_err_o, 1);

        do_reset();
        chk("pe_cleared_by_reset", proto_err_o, 0);

        // Randomized traffic against a round-robin reference model
        m_rd = '0; m_wr = '0; p_rd = '0; p_wr = '0;
        m_wd[0] = '0; m_wd[1] = '0; p_wd[0] = '0; p_wd[1] = '0;
        m_ptr = 0; m_owner = 0; cnt = 0; second = 1'b0; m_act = 1'b0; m_opw = 1'b0;
        n_txn = 0; m_rdata = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            just = '0;
            uart_read_response_i = 1'b0;
            uart_write_response_i = 1'b0;
            uart_read_data_i = $urandom;
            if (second) begin
                uart_write_response_i = 1'b1;
                second = 1'b0;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    if (m_opw) begin
                        uart_write_response_i = 1'b1;
                        second = 1'b1;
                    end else begin
                        uart_read_response_i = 1'b1;
                        uart_read_data_i = m_rdata;
                    end
                end
            end
            if (uart_read_o || uart_write_o) begin
                e = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (e < 0 && (p_rd[idx] || p_wr[idx])) e = idx;
                end
                if (e < 0) begin
                    chk("rnd_issue_unexpected", 1, 0);
                end else begin
                    chk("rnd_grant", grant_o, 64'd1 << e);
                    m_owner = e;
                    m_opw = p_wr[e];
                    chk("rnd_op", {uart_write_o, uart_read_o}, m_opw ? 2'b10 : 2'b01);
                    if (m_opw) chk("rnd_wdata", uart_write_data_o, p_wd[e]);
                    cnt = int'($urandom_range(1, 4));
                    m_rdata = $urandom;
                    m_act = 1'b1;
                end
            end
            if ((|req_read_response_o) || (|req_write_response_o)) begin
                if (!m_act) begin
                    chk("rnd_resp_unexpected", 1, 0);
                end else begin
                    chk("rnd_wresp", req_write_response_o, m_opw ? (64'd1 << m_owner) : 64'd0);
                    chk("rnd_rresp", req_read_response_o, m_opw ? 64'd0 : (64'd1 << m_owner));
                    if (!m_opw) chk("rnd_rdata", req_read_data_o, m_rdata);
                    m_ptr = (m_owner + 1) % N;
                    if (m_opw) m_wr[m_owner] = 1'b0;
                    else m_rd[m_owner] = 1'b0;
                    just[m_owner] = 1'b1;
                    m_act = 1'b0;
                    n_txn++;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!m_rd[i] && !m_wr[i] && !just[i] && $urandom_range(0, 3) == 0) begin
                    op = 2'($urandom_range(1, 3));
                    m_rd[i] = op[0];
                    m_wr[i] = op[1];
                    m_wd[i] = $urandom;
                end
            end
            req_read_i = m_rd;
            req_write_i = m_wr;
            req_write_data_i = {m_wd[1], m_wd[0]};
            p_rd = m_rd;
            p_wr = m_wr;
            p_wd = m_wd;
        end
        chk("rnd_txn_count", (n_txn >= 100) ? 1 : 0, 1);
        chk("rnd_no_err", proto_err_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
